// File: rtl/mm2s_pixel_unpacker.sv
// Unpacks 64-bit DMA stream words into 24-bit little-endian RGB pixels and
// tracks frame boundaries, flagging frames whose last pixel leaves stray bytes.
module mm2s_pixel_unpacker #(
  parameter int FRAME_PIXELS = 1280*720,
  parameter int PIX_COUNT_W  = 20
) (
  input  logic        m_axi_acp_aclk,
  input  logic        axi_resetn,
  input  logic        flush,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_done,
  output logic        align_err
);

  localparam logic [PIX_COUNT_W-1:0] LAST_PIX = PIX_COUNT_W'(FRAME_PIXELS - 1);

  logic [127:0]           buf_q, buf_d;
  logic [127:0]           shifted, wr_mask, wr_data;
  logic [4:0]             fill_q, fill_d;
  logic [4:0]             base;
  logic [7:0]             bit_off;
  logic [PIX_COUNT_W-1:0] pcnt_q, pcnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   align_err_q, align_err_d;
  logic                   s_hs, p_hs;

  assign s_ready    = (fill_q <= 5'd8) & ~flush;
  assign pix_valid  = (fill_q >= 5'd3) & ~flush;
  assign pix_data   = buf_q[23:0];
  assign pix_last   = pix_valid & (pcnt_q == LAST_PIX);
  assign frame_done = frame_done_q;
  assign align_err  = align_err_q;

  assign s_hs = s_valid & s_ready;
  assign p_hs = pix_valid & pix_ready;

  always_comb begin
    shifted = p_hs ? {24'd0, buf_q[127:24]} : buf_q;
    base    = p_hs ? (fill_q - 5'd3) : fill_q;
    bit_off = {base, 3'b000};
    // The incoming word lands right after the bytes that survive this cycle's pop.
    wr_mask = {64'd0, {64{1'b1}}} << bit_off;
    wr_data = {64'd0, s_data} << bit_off;
    buf_d   = s_hs ? ((shifted & ~wr_mask) | wr_data) : shifted;
    fill_d  = s_hs ? (base + 5'd8) : base;

    pcnt_d = pcnt_q;
    if (p_hs) begin
      pcnt_d = pix_last ? '0 : pcnt_q + PIX_COUNT_W'(1);
    end
    frame_done_d = p_hs & pix_last;
    // On the last pixel, base equals the bytes left over from this frame.
    align_err_d  = align_err_q | (p_hs & pix_last & (base != 5'd0));

    if (flush) begin
      fill_d       = '0;
      pcnt_d       = '0;
      frame_done_d = 1'b0;
      align_err_d  = 1'b0;
    end
  end

  always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      buf_q        <= '0;
      fill_q       <= '0;
      pcnt_q       <= '0;
      frame_done_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      pcnt_q       <= pcnt_d;
      frame_done_q <= frame_done_d;
      align_err_q  <= align_err_d;
    end
  end

endmodule

// File: tb/tb_mm2s_pixel_unpacker.sv
// Directed bench for mm2s_pixel_unpacker: a vector table for the first burst,
// then streamed sequences against a byte-counter model of the buffer.
module tb_mm2s_pixel_unpacker;

  localparam int FRAME_PIXELS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        frame_done;
  logic        align_err;

  int checks = 0;
  int errors = 0;
  int wr_byte, rd_byte, frame_pos;
  bit fd_expect, err_model;

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic        pr;
    logic        exp_sready;
    logic        exp_pvalid;
    logic        chk_pd;
    logic [23:0] exp_pdata;
  } vec_t;

  vec_t vecs[10];

  mm2s_pixel_unpacker #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .PIX_COUNT_W (20)
  ) dut (
    .m_axi_acp_aclk(clk),
    .axi_resetn    (rst_n),
    .flush         (flush),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_last      (pix_last),
    .frame_done    (frame_done),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] make_word(input int b);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(b + i);
    return w;
  endfunction

  function automatic logic [23:0] make_pix(input int b);
    return {8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  // Streams n_words of incrementing bytes with pix_ready high until n_pix pixels pop.
  task automatic apply_stimulus(input int n_words, input int n_pix);
    int sent = 0;
    int got = 0;
    int cycles = 0;
    int level;
    bit s_hs, p_hs, last;
    while (sent < n_words || got < n_pix) begin
      s_valid   = (sent < n_words);
      s_data    = make_word(wr_byte);
      pix_ready = 1'b1;
      @(negedge clk);
      level = wr_byte - rd_byte;
      check_output("s_ready", s_ready, level <= 8);
      check_output("pix_valid", pix_valid, level >= 3);
      check_output("frame_done", frame_done, fd_expect);
      check_output("align_err", align_err, err_model);
      s_hs = s_valid && (level <= 8);
      p_hs = (got < n_pix) && (level >= 3);
      pix_ready = p_hs;
      fd_expect = 1'b0;
      if (p_hs) begin
        last = (frame_pos == FRAME_PIXELS - 1);
        check_output("pix_data", pix_data, make_pix(rd_byte));
        check_output("pix_last", pix_last, last);
        if (last && level != 3) err_model = 1'b1;
        fd_expect = last;
        frame_pos = last ? 0 : frame_pos + 1;
        rd_byte += 3;
        got++;
      end
      if (s_hs) begin
        wr_byte += 8;
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (cycles > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL stream_timeout: ran %0d cycles, required at most 200", cycles);
        break;
      end
    end
    s_valid   = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    level = wr_byte - rd_byte;
    check_output("idle_frame_done", frame_done, fd_expect);
    check_output("idle_align_err", align_err, err_model);
    check_output("idle_pix_valid", pix_valid, level >= 3);
    fd_expect = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    pix_ready = 1'b0;
    wr_byte   = 0;
    rd_byte   = 0;
    frame_pos = 0;
    fd_expect = 1'b0;
    err_model = 1'b0;

    vecs[0] = '{1'b1, 64'h0706050403020100, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000};
    vecs[1] = '{1'b1, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b1, 1'b1, 1'b1, 24'h020100};
    vecs[2] = '{1'b1, 64'h1716151413121110, 1'b1, 1'b0, 1'b1, 1'b1, 24'h050403};
    vecs[3] = '{1'b1, 64'h1716151413121110, 1'b1, 1'b0, 1'b1, 1'b1, 24'h080706};
    vecs[4] = '{1'b1, 64'h1716151413121110, 1'b1, 1'b1, 1'b1, 1'b1, 24'h0B0A09};
    vecs[5] = '{1'b0, 64'h0,                1'b1, 1'b0, 1'b1, 1'b1, 24'h0E0D0C};
    vecs[6] = '{1'b0, 64'h0,                1'b1, 1'b0, 1'b1, 1'b1, 24'h11100F};
    vecs[7] = '{1'b0, 64'h0,                1'b1, 1'b1, 1'b1, 1'b1, 24'h141312};
    vecs[8] = '{1'b0, 64'h0,                1'b1, 1'b1, 1'b1, 1'b1, 24'h171615};
    vecs[9] = '{1'b0, 64'h0,                1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_s_ready", s_ready, 1);
    check_output("rst_pix_valid", pix_valid, 0);
    check_output("rst_pix_data", pix_data, 0);
    check_output("rst_pix_last", pix_last, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_align_err", align_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      s_valid   = vecs[i].sv;
      s_data    = vecs[i].sd;
      pix_ready = vecs[i].pr;
      @(negedge clk);
      check_output($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_sready);
      check_output($sformatf("vec%0d_pix_valid", i), pix_valid, vecs[i].exp_pvalid);
      if (vecs[i].chk_pd) check_output($sformatf("vec%0d_pix_data", i), pix_data, vecs[i].exp_pdata);
      check_output($sformatf("vec%0d_pix_last", i), pix_last, 0);
      @(posedge clk);
      #1;
    end
    s_valid   = 1'b0;
    pix_ready = 1'b0;
    check_output("basic_fill", dut.fill_q, 0);
    wr_byte   = 24;
    rd_byte   = 24;
    frame_pos = 8;

    // Words 4-6 finish the 16-pixel frame exactly on a word boundary.
    apply_stimulus(3, 8);
    check_output("frame_pcnt", dut.pcnt_q, 0);
    check_output("frame_align_err", align_err, 0);

    // A 7th word arrives before the last pixel, leaving 8 stray bytes.
    apply_stimulus(7, 18);
    check_output("misalign_err", align_err, 1);

    apply_stimulus(2, 5);
    flush     = 1'b1;
    s_valid   = 1'b1;
    s_data    = make_word(wr_byte);
    pix_ready = 1'b1;
    @(negedge clk);
    check_output("flush_s_ready", s_ready, 0);
    check_output("flush_pix_valid", pix_valid, 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    s_valid   = 1'b0;
    pix_ready = 1'b0;
    check_output("flush_fill", dut.fill_q, 0);
    check_output("flush_pcnt", dut.pcnt_q, 0);
    check_output("flush_pix_valid_after", pix_valid, 0);
    check_output("flush_align_err", align_err, 0);
    check_output("flush_frame_done", frame_done, 0);
    rd_byte   = wr_byte;
    frame_pos = 0;
    err_model = 1'b0;
    fd_expect = 1'b0;
    apply_stimulus(3, 8);
    check_output("restart_pcnt", dut.pcnt_q, 8);

    for (int k = 0; k < 2; k++) begin
      s_valid   = 1'b1;
      s_data    = make_word(wr_byte);
      pix_ready = 1'b0;
      @(negedge clk);
      check_output("bp_s_ready_open", s_ready, 1);
      @(posedge clk);
      #1;
      wr_byte += 8;
    end
    s_data = make_word(wr_byte);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("bp_s_ready_full", s_ready, 0);
      check_output("bp_pix_valid", pix_valid, 1);
      check_output("bp_pix_data", pix_data, make_pix(rd_byte));
      check_output("bp_pix_last", pix_last, 0);
      @(posedge clk);
      #1;
    end
    check_output("bp_fill", dut.fill_q, 16);
    apply_stimulus(1, 8);

    apply_stimulus(2, 3);
    check_output("pre_reset_fill", dut.fill_q, 7);
    @(negedge clk);
    #2;
    check_output("pre_reset_pix_valid", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    check_output("async_pix_valid", pix_valid, 0);
    check_output("async_s_ready", s_ready, 1);
    check_output("async_pix_data", pix_data, 0);
    check_output("async_fill", dut.fill_q, 0);
    #10;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm2s_pixel_unpacker.md
# mm2s_pixel_unpacker

Converts the 64-bit memory-to-stream output of the ACP DMA into a stream of 24-bit RGB pixels, one pixel per handshake, and marks frame boundaries. It sits directly downstream of the DMA's mm2s stream port and feeds the accelerator's pixel input. Frames are packed RGB, 3 bytes per pixel, little-endian byte order, so every 3 bus words carry exactly 8 pixels.

## Interface
Parameters:
- FRAME_PIXELS, 1280*720, pixels per frame; must be a non-zero multiple of 8.
- PIX_COUNT_W, 20, width of the pixel counter; 2^PIX_COUNT_W must be ≥ FRAME_PIXELS.

Ports:
- m_axi_acp_aclk  in  1  sole clock, rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear: drops buffered bytes and restarts the frame count.
- s_data  in  64  word from DMA mm2s_data; byte b is s_data[8b+7:8b].
- s_valid  in  1  from DMA mm2s_valid.
- s_ready  out  1  to DMA mm2s_ready.
- pix_data  out  24  pixel, {byte2, byte1, byte0}; byte0 is the lowest stream address.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accept.
- pix_last  out  1  high with the final pixel of a frame.
- frame_done  out  1  one-cycle pulse after the final pixel handshake.
- align_err  out  1  sticky error flag; cleared only by reset or flush.

## Operation
- The block holds a 128-bit byte buffer `buf` and a fill count `fill` of 0..16 bytes (5 bits). Byte 0 of `buf` is the oldest byte.
- Handshakes:
  - s_hs = s_valid & s_ready.
  - p_hs = pix_valid & pix_ready.
  - s_ready = (fill ≤ 8) & ~flush. This is combinational from registers plus flush.
  - pix_valid = (fill ≥ 3) & ~flush.
  - pix_data = buf[23:0].
- Per-cycle update, with c = 3 if p_hs else 0:
  - On p_hs, buf shifts right 24 bits.
  - On s_hs, the 8 bytes of s_data are written at byte offset (fill − c) of the shifted buffer.
  - fill_next = fill − c + (s_hs ? 8 : 0).
  - Simultaneous s_hs and p_hs is legal and required for full throughput.
- Pixel counter `pcnt` (PIX_COUNT_W bits):
  - Increments on p_hs.
  - pix_last = pix_valid & (pcnt == FRAME_PIXELS−1).
  - On p_hs with pix_last, pcnt wraps to 0 and frame_done pulses in the next cycle.
- Alignment check: on the last-pixel handshake, fill_next must be 0 unless an s_hs occurs in the same cycle.
  - The leftover-byte count is fill − 3 before the s_hs contribution.
  - If that count is nonzero, align_err is set. Data continues to flow; it is not dropped.
- flush has priority over everything:
  - Next cycle: fill = 0, pcnt = 0, align_err = 0.
  - frame_done does not pulse.
  - While flush is high, no handshake occurs on either side.
- Bytes above `fill` are don't-care. Verification checks only buf[8·fill−1:0].

## Timing
- Reset (async assert, sync-release assumed at the system level):
  - fill = 0, pcnt = 0.
  - pix_valid = 0, pix_last = 0, frame_done = 0, align_err = 0.
  - s_ready = 1, since fill = 0 and flush is low.
  - pix_data = 0, because buf resets to 0.
- Latency: a word accepted at edge N into an empty buffer gives pix_valid = 1 after edge N, with that word's pixel 0 on pix_data.
- Throughput: 1 pixel per cycle sustained when s_valid and pix_ready stay high. s_ready deasserts only while fill ≥ 9.
- pix_data, pix_valid and pix_last are stable while pix_valid & ~pix_ready, unless flush is asserted.
- Reset asserted mid-frame discards all buffered bytes immediately, with no output glitch requirement beyond the values listed above.

## Test plan
- Basic unpack:
  - Stimulus: words 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110, pix_ready held 1.
  - Required: 8 pixels, in order 0x020100, 0x050403, 0x080706, 0x0B0A09, 0x0E0D0C, 0x11100F, 0x141312, 0x171615; fill returns to 0.
- Back-pressure:
  - Stimulus: the same 3 words with s_valid held 1 and pix_ready held 0.
  - Required: s_ready drops after 2 words (fill = 16). pix_data stays 0x020100. No data is lost after pix_ready is released.
- Frame boundary:
  - Stimulus: FRAME_PIXELS = 16, 6 words streamed.
  - Required: pix_last only on pixel 15; frame_done pulses 1 cycle after that handshake; pcnt = 0; align_err = 0.
- Misalignment:
  - Stimulus: FRAME_PIXELS = 16, 7 words streamed, with the 7th word accepted before the last pixel.
  - Required: align_err = 1 after the pixel-15 handshake; the remaining bytes still emerge as pixels.
- Flush mid-frame:
  - Stimulus: after 5 pixels, assert flush for 1 cycle.
  - Required: next cycle fill = 0, pix_valid = 0, pcnt = 0, no frame_done. A new 3-word burst restarts at pixel 0.
- Async reset:
  - Stimulus: axi_resetn driven low mid-cycle with fill = 7.
  - Required: pix_valid = 0 and s_ready = 1 immediately, without waiting for a clock edge.
